// File: rtl/adc_axil_pkg.sv
// Shared definitions for the ADC AXI4-Lite register block.
// Contents: register offsets (word index, addr[3:2]), the AXI response code,
// the write/read channel state enums, STATUS bit positions and a byte-strobe
// merge helper.
package adc_axil_pkg;

  // Register word offsets, decoded from addr[3:2]
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_CLKDIV = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_DATA   = 2'd3;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // STATUS register layout
  localparam int STATUS_DATA_VALID_BIT = 0;
  localparam int STATUS_OVERFLOW_BIT   = 1;
  localparam int STATUS_COUNT_LSB      = 16;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  // Replace each byte of old_val whose strobe bit is set with the new byte.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_val[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/adc_sample_capture.sv
// Sample capture for the ADC register block.
// Holds the latest sample, the data_valid flag, the sticky overflow flag and
// a free-running 16-bit sample counter.
// Ports:
//   clock, reset      - clock, synchronous active-high reset
//   capture           - sample strobe already qualified by adc_enable
//   sample_in         - converted sample
//   rd_clear          - DATA register read accepted this cycle
//   ovf_clear         - W1C clear of overflow this cycle
//   sample, data_valid, overflow, sample_count - registered state
module adc_sample_capture #(
  parameter int ADC_WIDTH = 12
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 capture,
  input  logic [ADC_WIDTH-1:0] sample_in,
  input  logic                 rd_clear,
  input  logic                 ovf_clear,
  output logic [ADC_WIDTH-1:0] sample,
  output logic                 data_valid,
  output logic                 overflow,
  output logic [15:0]          sample_count
);

  logic [ADC_WIDTH-1:0] sample_q, sample_d;
  logic                 data_valid_q, data_valid_d;
  logic                 overflow_q, overflow_d;
  logic [15:0]          sample_count_q, sample_count_d;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch,
    // so no path leaves a value unassigned and no latch is inferred.
    sample_d       = sample_q;
    data_valid_d   = data_valid_q;
    overflow_d     = overflow_q;
    sample_count_d = sample_count_q;

    if (rd_clear)  data_valid_d = 1'b0;
    if (ovf_clear) overflow_d   = 1'b0;

    if (capture) begin
      sample_d       = sample_in;
      data_valid_d   = 1'b1;
      sample_count_d = sample_count_q + 16'd1;
      // An unread sample is being overwritten, unless the same-cycle DATA
      // read is consuming it. Placed after the W1C so a set wins.
      if (data_valid_q && !rd_clear) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: the sample latch is ordinary state, so it is reset along with
    // everything else; software must never see a stale pre-reset value.
    if (reset) begin
      sample_q       <= '0;
      data_valid_q   <= 1'b0;
      overflow_q     <= 1'b0;
      sample_count_q <= '0;
    end else begin
      sample_q       <= sample_d;
      data_valid_q   <= data_valid_d;
      overflow_q     <= overflow_d;
      sample_count_q <= sample_count_d;
    end
  end

  assign sample       = sample_q;
  assign data_valid   = data_valid_q;
  assign overflow     = overflow_q;
  assign sample_count = sample_count_q;

endmodule

// File: rtl/adc_axil_regs.sv
// AXI4-Lite slave register file for the ADC front end.
// Registers: CTRL (0x0), CLKDIV (0x4), STATUS (0x8), DATA (0xC).
// Ports:
//   clock, reset             - clock, synchronous active-high reset
//   s_axi_aw*/w*/b*          - AXI4-Lite write channels
//   s_axi_ar*/r*             - AXI4-Lite read channels
//   adc_sample(_valid)       - converted sample and its one-cycle strobe
//   adc_enable, adc_clkdiv   - control outputs (CTRL[0], CLKDIV[15:0])
// The ready signals are registered: a ready pulse is raised one cycle after
// the request is seen, and the transfer happens in the ready cycle.
module adc_axil_regs
  import adc_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int ADC_WIDTH          = 12
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                      s_axi_awprot,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                      s_axi_arprot,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  input  logic [ADC_WIDTH-1:0]            adc_sample,
  input  logic                            adc_sample_valid,
  output logic                            adc_enable,
  output logic [15:0]                     adc_clkdiv
);

  // Protection bits and byte-lane address bits carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awprot, s_axi_arprot,
                           s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  wr_state_t   wr_state_q, wr_state_d;
  rd_state_t   rd_state_q, rd_state_d;
  logic        awready_q, awready_d;
  logic        wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] ctrl_q, ctrl_d;
  logic [15:0] clkdiv_q, clkdiv_d;

  logic                 wr_fire, rd_fire;
  logic                 rd_clear, ovf_clear, capture;
  logic [31:0]          rd_mux;
  logic [ADC_WIDTH-1:0] cap_sample;
  logic                 cap_data_valid, cap_overflow;
  logic [15:0]          cap_count;

  assign wr_fire = awready_q && s_axi_awvalid && wready_q && s_axi_wvalid;
  assign rd_fire = arready_q && s_axi_arvalid;

  // Enable comes from the registered CTRL, so a CTRL write in the same cycle
  // as a strobe only affects later strobes.
  assign capture   = adc_sample_valid && ctrl_q[0];
  assign rd_clear  = rd_fire && (s_axi_araddr[3:2] == ADDR_DATA);
  assign ovf_clear = wr_fire && (s_axi_awaddr[3:2] == ADDR_STATUS) &&
                     s_axi_wstrb[0] && s_axi_wdata[STATUS_OVERFLOW_BIT];

  adc_sample_capture #(.ADC_WIDTH(ADC_WIDTH)) u_capture (
    .clock        (clock),
    .reset        (reset),
    .capture      (capture),
    .sample_in    (adc_sample),
    .rd_clear     (rd_clear),
    .ovf_clear    (ovf_clear),
    .sample       (cap_sample),
    .data_valid   (cap_data_valid),
    .overflow     (cap_overflow),
    .sample_count (cap_count)
  );

  // Write channel and register updates
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so later statements see
    // earlier ones; the clocked block below uses only non-blocking '<='.
    wr_state_d = wr_state_q;
    awready_d  = 1'b0;
    wready_d   = 1'b0;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    ctrl_d     = ctrl_q;
    clkdiv_d   = clkdiv_q;

    case (wr_state_q)
      W_IDLE: begin
        if (wr_fire) begin
          bvalid_d   = 1'b1;
          bresp_d    = RESP_OKAY;
          wr_state_d = W_RESP;
        end else if (s_axi_awvalid && s_axi_wvalid && !awready_q) begin
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          bvalid_d   = 1'b0;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase

    if (wr_fire) begin
      case (s_axi_awaddr[3:2])
        ADDR_CTRL: ctrl_d = apply_wstrb(ctrl_q, s_axi_wdata, s_axi_wstrb);
        ADDR_CLKDIV: begin
          if (s_axi_wstrb[0]) clkdiv_d[7:0]  = s_axi_wdata[7:0];
          if (s_axi_wstrb[1]) clkdiv_d[15:8] = s_axi_wdata[15:8];
        end
        default: ;  // STATUS handled via ovf_clear, DATA is read-only
      endcase
    end
  end

  // Read data mux, built from current (pre-write) register values
  always_comb begin
    rd_mux = '0;
    case (s_axi_araddr[3:2])
      ADDR_CTRL:   rd_mux = ctrl_q;
      ADDR_CLKDIV: rd_mux[15:0] = clkdiv_q;
      ADDR_STATUS: begin
        rd_mux[STATUS_DATA_VALID_BIT]     = cap_data_valid;
        rd_mux[STATUS_OVERFLOW_BIT]       = cap_overflow;
        rd_mux[STATUS_COUNT_LSB +: 16]    = cap_count;
      end
      default:     rd_mux[ADC_WIDTH-1:0] = cap_sample;
    endcase
  end

  // Read channel
  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = 1'b0;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;

    case (rd_state_q)
      R_IDLE: begin
        if (rd_fire) begin
          rdata_d    = rd_mux;
          rresp_d    = RESP_OKAY;
          rvalid_d   = 1'b1;
          rd_state_d = R_DATA;
        end else if (s_axi_arvalid && !arready_q) begin
          arready_d = 1'b1;
        end
      end
      R_DATA: begin
        if (s_axi_rready) begin
          rvalid_d   = 1'b0;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      ctrl_q     <= '0;
      clkdiv_q   <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      ctrl_q     <= ctrl_d;
      clkdiv_q   <= clkdiv_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign adc_enable    = ctrl_q[0];
  assign adc_clkdiv    = clkdiv_q;

endmodule

// File: tb/tb_adc_axil_regs.sv
// Self-checking bench for adc_axil_regs. Read and write-response expectations
// come from a transaction-level register model and are queued when a request
// is issued; monitor processes pop and compare on each R/B handshake.
module tb_adc_axil_regs;

  localparam int ADC_W = 12;

  logic              clock = 1'b0;
  logic              reset;
  logic [3:0]        s_axi_awaddr;
  logic [2:0]        s_axi_awprot;
  logic              s_axi_awvalid;
  logic              s_axi_awready;
  logic [31:0]       s_axi_wdata;
  logic [3:0]        s_axi_wstrb;
  logic              s_axi_wvalid;
  logic              s_axi_wready;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid;
  logic              s_axi_bready;
  logic [3:0]        s_axi_araddr;
  logic [2:0]        s_axi_arprot;
  logic              s_axi_arvalid;
  logic              s_axi_arready;
  logic [31:0]       s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rvalid;
  logic              s_axi_rready;
  logic [ADC_W-1:0]  adc_sample;
  logic              adc_sample_valid;
  logic              adc_enable;
  logic [15:0]       adc_clkdiv;

  always #5 clock = ~clock;

  adc_axil_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .ADC_WIDTH(ADC_W)
  ) dut (
    .clock(clock), .reset(reset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .adc_sample(adc_sample), .adc_sample_valid(adc_sample_valid),
    .adc_enable(adc_enable), .adc_clkdiv(adc_clkdiv)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] rd_q[$];
  logic [1:0]  b_q[$];

  // Reference model state
  logic [31:0] m_ctrl;
  logic [15:0] m_clkdiv;
  int          m_sample;
  bit          m_dv;
  bit          m_ovf;
  int          m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: DUT did not respond within the cycle budget", name);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic void m_reset();
    m_ctrl = 0; m_clkdiv = 0; m_sample = 0; m_dv = 0; m_ovf = 0; m_cnt = 0;
  endfunction

  function automatic logic [31:0] m_peek(input logic [3:0] a);
    int idx;
    idx = int'(a) / 4;
    case (idx)
      0:       return m_ctrl;
      1:       return {16'h0000, m_clkdiv};
      2:       return (32'(m_cnt) << 16) + (m_ovf ? 32'd2 : 32'd0) + (m_dv ? 32'd1 : 32'd0);
      default: return 32'(m_sample);
    endcase
  endfunction

  // A sample strobe; read_clearing means a DATA read is accepted in the same cycle.
  function automatic void m_strobe(input int s, input bit read_clearing);
    if (m_ctrl[0]) begin
      if (m_dv && !read_clearing) m_ovf = 1;
      m_dv     = 1;
      m_sample = s % (1 << ADC_W);
      m_cnt    = (m_cnt + 1) % 65536;
    end
  endfunction

  function automatic void m_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] strb);
    int idx;
    idx = int'(a) / 4;
    for (int i = 0; i < 4; i++) begin
      if (strb[i] && idx == 0) m_ctrl[8*i +: 8] = d[8*i +: 8];
      if (strb[i] && idx == 1 && i < 2) m_clkdiv[8*i +: 8] = d[8*i +: 8];
    end
    if (idx == 2 && strb[0] && d[1]) m_ovf = 0;
  endfunction

  // Monitors: compare on every completed R / B handshake
  logic [31:0] mon_rexp;
  always @(negedge clock) begin
    if (!reset && s_axi_rvalid && s_axi_rready) begin
      if (rd_q.size() == 0) begin
        fail_now("unexpected_rvalid");
      end else begin
        mon_rexp = rd_q.pop_front();
        check("rdata", s_axi_rdata, mon_rexp);
        check("rresp", {30'd0, s_axi_rresp}, 32'd0);
      end
    end
    if (!reset && s_axi_bvalid && s_axi_bready) begin
      if (b_q.size() == 0) begin
        fail_now("unexpected_bvalid");
      end else begin
        check("bresp", {30'd0, s_axi_bresp}, {30'd0, b_q.pop_front()});
      end
    end
  end

  task automatic axi_read(input logic [3:0] addr, input int r_delay, input bit strobe,
                          input int s, input bit use_lit, input logic [31:0] lit);
    logic [31:0] exp;
    int n;
    bit is_data;
    is_data = (addr[3:2] == 2'd3);
    exp = m_peek(addr);
    if (is_data) m_dv = 0;
    if (strobe) m_strobe(s, is_data);
    if (use_lit) exp = lit;
    rd_q.push_back(exp);
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    n = 0;
    tick();
    while (!s_axi_arready && n < 50) begin tick(); n++; end
    if (!s_axi_arready) begin
      fail_now("arready");
      s_axi_arvalid = 1'b0;
      void'(rd_q.pop_back());
      return;
    end
    if (strobe) begin
      adc_sample       = s[ADC_W-1:0];
      adc_sample_valid = 1'b1;
    end
    tick();
    s_axi_arvalid    = 1'b0;
    adc_sample_valid = 1'b0;
    for (int i = 0; i < r_delay; i++) begin
      check("rvalid_held", {31'd0, s_axi_rvalid}, 32'd1);
      check("rdata_held", s_axi_rdata, exp);
      tick();
    end
    s_axi_rready = 1'b1;
    n = 0;
    while (!s_axi_rvalid && n < 50) begin tick(); n++; end
    if (!s_axi_rvalid) begin
      fail_now("rvalid");
      void'(rd_q.pop_back());
    end else begin
      tick();
    end
    s_axi_rready = 1'b0;
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] d, input logic [3:0] strb,
                           input int aw_lead, input int w_lead, input int b_delay);
    int n;
    b_q.push_back(2'b00);
    s_axi_awaddr = addr;
    s_axi_wdata  = d;
    s_axi_wstrb  = strb;
    if (aw_lead > 0) begin
      s_axi_awvalid = 1'b1;
      repeat (aw_lead) begin
        tick();
        check("aw_alone_no_ready", {30'd0, s_axi_awready, s_axi_wready}, 32'd0);
      end
    end else if (w_lead > 0) begin
      s_axi_wvalid = 1'b1;
      repeat (w_lead) begin
        tick();
        check("w_alone_no_ready", {30'd0, s_axi_awready, s_axi_wready}, 32'd0);
      end
    end
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    n = 0;
    tick();
    while (!s_axi_awready && n < 50) begin tick(); n++; end
    if (!s_axi_awready) begin
      fail_now("awready");
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      void'(b_q.pop_back());
      return;
    end
    check("wready_with_awready", {31'd0, s_axi_wready}, 32'd1);
    tick();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    m_write(addr, d, strb);
    for (int i = 0; i < b_delay; i++) begin
      check("bvalid_held", {31'd0, s_axi_bvalid}, 32'd1);
      tick();
    end
    s_axi_bready = 1'b1;
    n = 0;
    while (!s_axi_bvalid && n < 50) begin tick(); n++; end
    if (!s_axi_bvalid) begin
      fail_now("bvalid");
      void'(b_q.pop_back());
    end else begin
      tick();
    end
    s_axi_bready = 1'b0;
    check("adc_enable", {31'd0, adc_enable}, {31'd0, m_ctrl[0]});
    check("adc_clkdiv", {16'd0, adc_clkdiv}, {16'd0, m_clkdiv});
  endtask

  task automatic strobe_sample(input int s);
    adc_sample       = s[ADC_W-1:0];
    adc_sample_valid = 1'b1;
    tick();
    adc_sample_valid = 1'b0;
    m_strobe(s, 1'b0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd0);
    check({tag, "_valid"}, {30'd0, s_axi_bvalid, s_axi_rvalid}, 32'd0);
    check({tag, "_rdata"}, s_axi_rdata, 32'd0);
    check({tag, "_resp"}, {28'd0, s_axi_bresp, s_axi_rresp}, 32'd0);
    check({tag, "_enable"}, {31'd0, adc_enable}, 32'd0);
    check({tag, "_clkdiv"}, {16'd0, adc_clkdiv}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset = 1'b1;
    s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    adc_sample = '0; adc_sample_valid = 1'b0;
    m_reset();
    repeat (3) tick();
    reset = 1'b0;
    check_idle_outputs("reset");

    // Basic write/readback
    axi_write(4'h0, 32'h0000_0001, 4'hF, 0, 0, 0);
    axi_write(4'h4, 32'h0000_0064, 4'hF, 0, 0, 0);
    check("t1_enable", {31'd0, adc_enable}, 32'd1);
    check("t1_clkdiv", {16'd0, adc_clkdiv}, 32'h64);
    axi_read(4'h0, 0, 0, 0, 1, 32'h0000_0001);
    axi_read(4'h4, 0, 0, 0, 1, 32'h0000_0064);

    // Byte strobes
    axi_write(4'h0, 32'hAABB_CCDD, 4'b0010, 0, 0, 0);
    axi_read(4'h0, 0, 0, 0, 1, 32'h0000_CC01);
    axi_write(4'h4, 32'hFFFF_1234, 4'b1100, 0, 0, 0);
    axi_read(4'h4, 0, 0, 0, 1, 32'h0000_0064);

    // Capture, STATUS, clear-on-read of DATA
    strobe_sample(12'hABC);
    axi_read(4'h8, 0, 0, 0, 1, 32'h0001_0001);
    axi_read(4'hC, 0, 0, 0, 1, 32'h0000_0ABC);
    axi_read(4'h8, 0, 0, 0, 1, 32'h0001_0000);

    // Overflow and W1C
    strobe_sample(12'h111);
    strobe_sample(12'h222);
    axi_read(4'h8, 0, 0, 0, 1, 32'h0003_0003);
    axi_write(4'h8, 32'h0000_0002, 4'h1, 0, 0, 0);
    axi_read(4'h8, 0, 0, 0, 1, 32'h0003_0001);
    axi_read(4'hD, 0, 0, 0, 1, 32'h0000_0222);

    // Sample strobe in the DATA-read acceptance cycle
    strobe_sample(12'h0F0);
    axi_read(4'hC, 0, 1, 12'h5A5, 1, 32'h0000_00F0);
    axi_read(4'h8, 0, 0, 0, 1, 32'h0005_0001);
    axi_read(4'hC, 0, 0, 0, 1, 32'h0000_05A5);

    // Strobe ignored while disabled; DATA write ignored
    axi_write(4'h0, 32'h0000_0000, 4'hF, 0, 0, 0);
    strobe_sample(12'h777);
    axi_write(4'hC, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    axi_read(4'h8, 0, 0, 0, 1, 32'h0005_0000);
    axi_read(4'hC, 0, 0, 0, 1, 32'h0000_05A5);

    // Backpressure and split AW/W
    axi_write(4'h4, 32'h0000_BEEF, 4'hF, 3, 0, 10);
    axi_write(4'h0, 32'h0000_0001, 4'hF, 0, 2, 2);
    axi_read(4'h4, 10, 0, 0, 1, 32'h0000_BEEF);

    // Reset while a read response is pending
    s_axi_araddr  = 4'h4;
    s_axi_arvalid = 1'b1;
    n = 0;
    tick();
    while (!s_axi_arready && n < 50) begin tick(); n++; end
    if (!s_axi_arready) fail_now("reset_test_arready");
    tick();
    s_axi_arvalid = 1'b0;
    check("rvalid_before_reset", {31'd0, s_axi_rvalid}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_reset();
    check_idle_outputs("midreset");
    for (int a = 0; a < 16; a += 4) axi_read(4'(a), 0, 0, 0, 1, 32'h0);
    axi_write(4'h4, 32'h0000_0033, 4'hF, 0, 0, 0);
    axi_read(4'h4, 0, 0, 0, 1, 32'h0000_0033);

    // Randomized traffic against the model
    for (int k = 0; k < 300; k++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 2) begin
        logic [31:0] d;
        int lead;
        d = $urandom;
        if ($urandom_range(0, 1) == 1) d[0] = 1'b1;
        lead = $urandom_range(0, 2);
        if ($urandom_range(0, 1) == 1)
          axi_write(4'($urandom_range(0, 15)), d, 4'($urandom_range(0, 15)), lead, 0,
                    $urandom_range(0, 3));
        else
          axi_write(4'($urandom_range(0, 15)), d, 4'($urandom_range(0, 15)), 0, lead,
                    $urandom_range(0, 3));
      end else if (op <= 6) begin
        axi_read(4'($urandom_range(0, 15)), $urandom_range(0, 3),
                 ($urandom_range(0, 4) == 0), int'($urandom_range(0, 4095)), 0, 32'h0);
      end else begin
        strobe_sample(int'($urandom_range(0, 4095)));
      end
    end

    repeat (5) tick();
    check("rd_queue_drained", rd_q.size(), 32'd0);
    check("b_queue_drained", b_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
